// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// squashes and data-memory freezes with a timeout watchdog, plus saturating event counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // RECOVER is the single forced-unfrozen cycle that follows a watchdog abort.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    RECOVER  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [TW-1:0]    tmo_inc;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic freeze;
  logic lu;
  logic branch_act;

  // Hazard detection is masked while in reset so the pipeline sees neutral controls.
  assign freeze = arst_n &
                  (((state_q == RUN) & dmem_req & ~dmem_ready) |
                   ((state_q == MEM_WAIT) & ~dmem_ready));
  assign lu = arst_n & idex_memread & (idex_rd != 5'd0) &
              ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));
  assign branch_act = arst_n & branch_taken;
  assign tmo_inc    = tmo_q + TW'(1);

  // NOTE: every output gets a default before the priority chain, so no latch is inferred.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    if (freeze) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      en_idex   = 1'b0;
      en_exmem  = 1'b0;
      en_memwb  = 1'b0;
    end else if (branch_act) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    mem_err_d = mem_err_q;
    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d = MEM_WAIT;
          tmo_d   = TW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          tmo_d   = '0;
        end else if (tmo_inc == TMO_LAST) begin
          state_d   = RECOVER;
          tmo_d     = '0;
          mem_err_d = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      RECOVER: state_d = RUN;
      default: begin
        state_d = RUN;
        tmo_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (pc_hold && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);
    if (ifid_flush && (flush_q != CNT_MAX)) flush_d = flush_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= RUN;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // Control vector order: {pc_hold, ifid_hold, ifid_flush, idex_bubble, en_idex, en_exmem, en_memwb}
  localparam logic [6:0] C_IDLE   = 7'b0000111;
  localparam logic [6:0] C_FREEZE = 7'b1100000;
  localparam logic [6:0] C_BRANCH = 7'b0011111;
  localparam logic [6:0] C_LU     = 7'b1101111;

  logic             clk = 1'b0;
  logic             arst_n;
  logic [4:0]       ifid_rs1, ifid_rs2, idex_rd;
  logic             idex_memread, branch_taken, dmem_req, dmem_ready;
  logic             pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic             en_idex, en_exmem, en_memwb, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .idex_rd      (idex_rd),
    .idex_memread (idex_memread),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .en_idex      (en_idex),
    .en_exmem     (en_exmem),
    .en_memwb     (en_memwb),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] last_ctrl;

  // Behavioural model: tracks whether we are inside a memory wait episode and how
  // many frozen cycles it has lasted, plus the sticky error and event totals.
  bit m_waiting;
  int m_waited;
  bit m_recover;
  bit m_err;
  int m_stall;
  int m_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_frozen();
    if (!arst_n) return 1'b0;
    if (m_waiting) return !dmem_ready;
    return !m_recover && dmem_req && !dmem_ready;
  endfunction

  function automatic logic [6:0] model_ctrl();
    bit load_use;
    if (!arst_n) return C_IDLE;
    load_use = idex_memread && (idex_rd != 0) && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
    if (m_frozen()) return C_FREEZE;
    if (branch_taken) return C_BRANCH;
    if (load_use) return C_LU;
    return C_IDLE;
  endfunction

  task automatic model_reset();
    m_waiting = 0;
    m_waited  = 0;
    m_recover = 0;
    m_err     = 0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  task automatic model_update();
    logic [6:0] c;
    bit fr;
    if (!arst_n) return;
    c  = model_ctrl();
    fr = m_frozen();
    if (c[6]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
    if (c[4]) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
    if (fr) begin
      m_waited++;
      if (m_waited == MEM_TIMEOUT) begin
        m_err     = 1;
        m_waiting = 0;
        m_waited  = 0;
        m_recover = 1;
      end else begin
        m_waiting = 1;
      end
    end else begin
      m_waiting = 0;
      m_waited  = 0;
      m_recover = 0;
    end
  endtask

  task automatic compare_all();
    last_ctrl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, en_idex, en_exmem, en_memwb};
    check("ctrl", 32'(last_ctrl), 32'(model_ctrl()));
    check("mem_err", 32'(mem_err), 32'(m_err));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic br, input logic req, input logic rdy);
    idex_memread = mr;
    idex_rd      = rd;
    ifid_rs1     = rs1;
    ifid_rs2     = rs2;
    branch_taken = br;
    dmem_req     = req;
    dmem_ready   = rdy;
  endtask

  // One pipeline cycle: apply inputs, compare mid-cycle, then advance the model on the edge.
  task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic br, input logic req, input logic rdy);
    @(negedge clk);
    drive(mr, rd, rs1, rs2, br, req, rdy);
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse taken wherever the caller currently is in the cycle.
  task automatic do_reset();
    #1;
    arst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    arst_n = 1'b1;
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    // Reset with a load-use and a pending memory request on the inputs: controls stay neutral.
    arst_n = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    model_reset();
    #3;
    compare_all();
    check("rst_ctrl", 32'(last_ctrl), 32'(C_IDLE));
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    arst_n = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    // Load-use: exactly one bubble cycle.
    step(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    check("lu_ctrl", 32'(last_ctrl), 32'(C_LU));
    idle();
    check("lu_after", 32'(last_ctrl), 32'(C_IDLE));
    check("lu_stall", 32'(stall_cnt), 32'd1);

    // x0 destination never stalls; branch beats a simultaneous load-use.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("x0_ctrl", 32'(last_ctrl), 32'(C_IDLE));
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    check("br_lu_ctrl", 32'(last_ctrl), 32'(C_BRANCH));
    idle();
    check("br_flush", 32'(flush_cnt), 32'd1);
    check("br_stall", 32'(stall_cnt), 32'd1);

    // Memory wait of three cycles, released in the ready cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check("mw_ctrl", 32'(last_ctrl), 32'(C_FREEZE));
    end
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    check("mw_release", 32'(last_ctrl), 32'(C_IDLE));
    check("mw_stall", 32'(stall_cnt), 32'd3);

    // Branch during a freeze is ignored, then acted on in the release cycle.
    do_reset();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    check("fb_frozen", 32'(last_ctrl), 32'(C_FREEZE));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    check("fb_release", 32'(last_ctrl), 32'(C_BRANCH));
    check("fb_flush", 32'(flush_cnt), 32'd1);

    // Watchdog: MEM_TIMEOUT frozen cycles, then a forced-unfrozen cycle with mem_err set.
    do_reset();
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check("wd_frozen", 32'(last_ctrl), 32'(C_FREEZE));
    end
    check("wd_err", 32'(mem_err), 32'd1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("wd_unfrozen", 32'(last_ctrl), 32'(C_IDLE));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("wd_refreeze", 32'(last_ctrl), 32'(C_FREEZE));
    check("wd_sticky", 32'(mem_err), 32'd1);
    check("wd_stall_sat", 32'(stall_cnt), 32'(CNT_MAX));

    // Reset in the middle of a memory wait.
    do_reset();
    check("rst_mw_err", 32'(mem_err), 32'd0);
    check("rst_mw_stall", 32'(stall_cnt), 32'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rst_mw_run", 32'(last_ctrl), 32'(C_IDLE));

    // Saturation: five load-use events on a 2-bit counter.
    for (int i = 0; i < 5; i++) step(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    check("sat_stall", 32'(stall_cnt), 32'(CNT_MAX));

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      step($urandom_range(0, 99) < 35,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 45);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage core. It drives the hold, flush, bubble and enable inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It covers three cases:
- load-use hazards, by inserting a one-cycle bubble;
- taken branches resolved in EX, by squashing two wrong-path instructions;
- multi-cycle data-memory accesses, by freezing the whole pipeline until the memory is ready, with a timeout watchdog.

It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum number of consecutive MEM_WAIT cycles before the watchdog fires (≥2).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous, active-low reset.
- ifid_rs1, ifid_rs2  in  5  source registers of the instruction in IF/ID.
- idex_rd  in  5  destination register of the instruction in ID/EX.
- idex_memread  in  1  instruction in ID/EX is a load.
- branch_taken  in  1  EX has resolved a taken branch or jump this cycle.
- dmem_req  in  1  EX/MEM instruction is accessing data memory this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_hold, ifid_hold  out  1  hold the PC / IF/ID register (the hazard input).
- ifid_flush  out  1  zero IF/ID at the next edge.
- idex_bubble  out  1  zero the ID/EX control fields at the next edge.
- en_idex, en_exmem, en_memwb  out  1  pipeline register enables.
- mem_err  out  1  sticky flag: the watchdog fired.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
States: RUN and MEM_WAIT. A 2-bit state register plus a timeout counter of width clog2(MEM_TIMEOUT+1).

Definitions:
- freeze = dmem_req & ~dmem_ready, evaluated in RUN, or the state is MEM_WAIT with dmem_ready=0.
- lu = idex_memread & (idex_rd≠0) & (idex_rd==ifid_rs1 | idex_rd==ifid_rs2).

All outputs except mem_err and the counters are combinational from the state and the current inputs (zero-cycle latency). They are resolved in priority order:
1. **freeze:** pc_hold=ifid_hold=1; en_idex=en_exmem=en_memwb=0; ifid_flush=idex_bubble=0.
2. **branch_taken:** ifid_flush=1, idex_bubble=1, holds=0, all enables=1. A branch overrides a simultaneous lu, because the dependent instruction is wrong-path.
3. **lu:** pc_hold=ifid_hold=1, idex_bubble=1, all enables=1.
4. **Otherwise:** holds, flush and bubble are 0; all enables are 1.

Transitions:
- RUN→MEM_WAIT when dmem_req & ~dmem_ready. The timeout counter loads 1.
- MEM_WAIT→RUN when dmem_ready=1. In that cycle freeze=0, so the release cycle evaluates the branch, lu and default rules normally.
- MEM_WAIT with dmem_ready=0: the counter increments. When it equals MEM_TIMEOUT, mem_err is set, the state goes to RUN, and the next cycle is forced unfrozen (dmem_req is ignored for that one cycle) so the pipeline advances.
- mem_err stays set until reset.

Counters:
- stall_cnt increments on every cycle with pc_hold=1 (freeze or lu).
- flush_cnt increments on every cycle with ifid_flush=1.
- Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- Reset (arst_n=0, asynchronous, takes effect immediately): state=RUN, timeout counter=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- Combinational outputs during reset: holds=0, flush=0, bubble=0, enables=1. The downstream registers are themselves held in reset.
- Load-use costs exactly 1 cycle. The same load cannot re-trigger, because the bubble clears idex_memread on the next edge.
- A taken branch costs 2 squashed instructions, flushed in 1 cycle.
- A memory access that is ready in the same cycle costs 0 stall cycles. A response after N wait cycles costs N stall cycles.
- Simultaneous freeze and branch_taken: freeze wins and branch_taken is ignored. EX is frozen, so branch_taken re-presents on the release cycle and is acted on then.
- Reset asserted during MEM_WAIT: the block returns to RUN immediately and mem_err is not set.
- A watchdog abort costs exactly MEM_TIMEOUT stall cycles.

## Test plan
- **Load-use:** idex_memread=1, idex_rd=5, ifid_rs2=5 for 1 cycle → pc_hold=ifid_hold=idex_bubble=1 for exactly 1 cycle; stall_cnt=1.
- **x0 / branch priority:** idex_rd=0 with a matching rs → no stall. Then lu together with branch_taken=1 → ifid_flush=idex_bubble=1, pc_hold=0; flush_cnt=1, stall_cnt unchanged.
- **Memory wait:** dmem_req=1 with dmem_ready low for 3 cycles, then high → en_exmem=en_memwb=en_idex=0 and pc_hold=1 for 3 cycles; the enables are 1 in the ready cycle; stall_cnt=3.
- **Freeze + branch:** branch_taken=1 during a freeze → no flush while frozen; ifid_flush=1 in the release cycle.
- **Watchdog:** MEM_TIMEOUT=4, dmem_ready held 0 → 4 frozen cycles, then mem_err=1 and the next cycle has enables=1 even with dmem_req=1; mem_err stays 1 until arst_n pulses low.
- **Saturation / reset:** CNT_W=2, 5 lu events → stall_cnt=3. Assert arst_n=0 mid-MEM_WAIT → state=RUN, counters=0, mem_err=0.
